// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable latency and valid/ready response
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] word, load_val, store_val, wrep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic        misalign, mem_we;

  // Addresses outside the array wrap onto it by keeping only the index bits.
  assign idx  = AW'((addr_q - BASE) >> 2);
  assign word = mem[idx];

  always_comb begin
    byte_sel = word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? word[31:16] : word[15:0];
    load_val = word;
    be       = 4'b1111;
    wrep     = wdata_q;
    case (op_q[1:0])
      2'b00: begin
        load_val = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
        be       = 4'b0001 << addr_q[1:0];
        wrep     = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_val = {{16{~op_q[2] & half_sel[15]}}, half_sel};
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata_q[15:0]}};
      end
      default: begin
        load_val = word;
        be       = 4'b1111;
        wrep     = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      store_val[i*8 +: 8] = be[i] ? wrep[i*8 +: 8] : word[i*8 +: 8];
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ((op_q[1:0] == 2'b01) && addr_q[0]) ||
                    (op_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = wen_q & ~misalign;
          rdata_d = (wen_q | misalign) ? 32'd0 : load_val;
          err_d   = misalign;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A store whose commit edge coincides with reset is discarded.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[idx] <= store_val;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .BASE(32'h80000000), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got response %h expected none", resp_rdata);
      end else begin
        e = sb.pop_front();
        chk("sb_rdata", resp_rdata, e.rdata);
        chk("sb_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic txn(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    sb.push_back('{exp_rdata, exp_err});
    #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!resp_valid && n < 20);
    chk("latency", 32'(n), 32'(LAT));
    @(posedge clk); #1;
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("rdata_clear", resp_rdata, 32'd0);
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 3'b010, 32'h80000010, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 3'b000, 32'h80000011, 32'hFFFFFF80, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 3'b010, 32'h80000010, 32'h0, 32'hDEAD80EF, 1'b0};
    vt[4]  = '{1'b0, 3'b000, 32'h80000011, 32'h0, 32'hFFFFFF80, 1'b0};
    vt[5]  = '{1'b0, 3'b100, 32'h80000011, 32'h0, 32'h00000080, 1'b0};
    vt[6]  = '{1'b0, 3'b001, 32'h80000012, 32'h0, 32'hFFFFDEAD, 1'b0};
    vt[7]  = '{1'b0, 3'b101, 32'h80000012, 32'h0, 32'h0000DEAD, 1'b0};
    vt[8]  = '{1'b1, 3'b101, 32'h80000012, 32'hAAAA1234, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 3'b010, 32'h80000010, 32'h0, 32'h123480EF, 1'b0};
    vt[10] = '{1'b1, 3'b010, 32'h80000020, 32'h0, 32'h0, 1'b0};
    vt[11] = '{1'b1, 3'b010, 32'h80001000, 32'hA5A5A5A5, 32'h0, 1'b0};
    vt[12] = '{1'b0, 3'b010, 32'h80000000, 32'h0, 32'hA5A5A5A5, 1'b0};
    vt[13] = '{1'b0, 3'b010, 32'h80000002, 32'h0, CHK ? 32'h0 : 32'hA5A5A5A5, CHK};
    vt[14] = '{1'b0, 3'b000, 32'h80000003, 32'h0, 32'hFFFFFFA5, 1'b0};
    vt[15] = '{1'b1, 3'b010, 32'h80000001, 32'hFFFFFFFF, 32'h0, CHK};
    vt[16] = '{1'b0, 3'b011, 32'h80000000, 32'h0, CHK ? 32'hA5A5A5A5 : 32'hFFFFFFFF, 1'b0};
    vt[17] = '{1'b0, 3'b001, 32'h80000001, 32'h0, CHK ? 32'h0 : 32'hFFFFFFFF, CHK};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 18; i++) begin
      txn(vt[i].wen, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err);
    end

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_op = 3'b010; req_addr = 32'h80000010;
    @(posedge clk);
    sb.push_back('{32'h123480EF, 1'b0});
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h123480EF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 32'(resp_valid), 32'd0);
    chk("bp_req_ready_rise", 32'(req_ready), 32'd1);

    // Reset landing on the commit edge of a store discards it.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_op = 3'b010;
    req_addr = 32'h80000020; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h80000020, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory interface: accepts one load/store request at a time from the core's load/store path.
- Performs the access on an internal word array after a programmable latency and returns a response over a valid/ready handshake.
- Replaces the zero-latency data memory in multi-cycle and pipelined core bring-up.
- Uses the core's MemOp encoding so the control-signal generator output connects unchanged.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; power of two.
- BASE, 32'h80000000: byte address mapped to word 0.
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  MemOp. [1:0] size: 00 byte, 01 half, 10 word. [2] zero-extend (loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load result, extended per req_op; 0 for stores.
- resp_err  out  1  access error (only with the optional feature).

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Next state IDLE. Latency counter=0.
  - Any pending request is dropped; a pending store is NOT written.
  - Array contents are not reset.
- States: IDLE, BUSY, RESP. req_ready=1 only in IDLE.
- IDLE: on posedge with req_valid=1:
  - Latch wen, op, addr, wdata.
  - Load counter with LATENCY-1.
  - Go to BUSY. req_ready drops to 0 on the same edge.
- BUSY: each posedge, if counter!=0 then decrement. If counter==0:
  - Perform the access.
  - Register resp_rdata and resp_err.
  - Set resp_valid=1 and go to RESP.
- Net latency: a request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
- RESP: resp_valid, resp_rdata and resp_err are held stable until a posedge with resp_ready=1. On that edge:
  - resp_valid=0 and resp_rdata=0.
  - Go to IDLE; req_ready=1 after that edge.
  - A new request is not accepted on the same edge; minimum request spacing is LATENCY+2 cycles.
- Index: idx = ((addr - BASE) >> 2) mod DEPTH; out-of-range addresses wrap silently. Byte lane = addr[1:0].
- Loads:
  - Byte: lane byte, sign-extended from bit 7, or zero-extended if op[2]=1.
  - Half: the half at addr[1] (addr[0] ignored), sign/zero-extended from bit 15.
  - Word: full word (addr[1:0] ignored).
  - op[1:0]=11: treated as word.
- Stores:
  - Byte: writes wdata[7:0] to the lane.
  - Half: writes wdata[15:0] to half addr[1].
  - Word: writes all 4 bytes.
  - Other bytes in the word are unchanged; op[2] is ignored.
  - The write commits on the BUSY->RESP edge; resp_rdata=0.
- Read after write: a load accepted after a store's response completes returns the stored data.
- Requester contract: req_* may change freely while req_ready=0; they are only sampled at acceptance.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, gives resp_err=1 and resp_rdata=0.
  - No array write occurs; timing is unchanged.
  - resp_err is otherwise 0.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned low address bits are ignored as described under Behaviour.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Word store then load, LATENCY=2:
  - sw 32'hDEADBEEF to 0x80000010, resp_ready=1 -> resp_valid exactly 2 cycles after acceptance.
  - lw 0x80000010 -> resp_rdata=32'hDEADBEEF.
- Byte/half lanes, over the word at 0x80000010 = 32'hDEADBEEF:
  - sb 8'h80 to 0x80000011; lw -> 32'hDEAD80EF.
  - lb 0x80000011 -> 32'hFFFFFF80; lbu -> 32'h00000080.
  - lh 0x80000012 -> 32'hFFFFDEAD; lhu -> 32'h0000DEAD.
- Backpressure:
  - lw with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held constant, req_ready=0 throughout.
  - Raise resp_ready -> resp_valid falls next edge; req_ready rises that edge.
- Reset mid-operation:
  - sw 32'h12345678 to 0x80000020 (prior word 0); pull rst=0 while in BUSY.
  - Then lw 0x80000020 -> 32'h00000000, i.e. the store was discarded.
- Wrap and misalign, DEPTH=1024:
  - sw 32'hA5A5A5A5 to 0x80001000; lw 0x80000000 -> 32'hA5A5A5A5.
  - lw 0x80000002 -> resp_err=1 with DMEM_MISALIGN_CHK_EN; 32'hA5A5A5A5, err=0 without.
